// File: rtl/sys_defs.sv
// Shared system definitions: bus widths and the bus command encoding.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define XLEN        32
`define DATA_LENGTH 64

package sys_defs;
   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;
endpackage

`endif

// File: rtl/rr_arbiter.sv
// Grant selector: one-hot grant over req, searching from ptr (round-robin)
// or from index 0 (fixed priority).
module rr_arbiter #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned RR_MODE = 1,
   localparam int unsigned PTR_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant
);

   int unsigned      start;
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      start = (RR_MODE != 0) ? int'(ptr) : 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = PTR_W'((start + i) % NUM_CH);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: forwards one request per cycle to memory,
// tracks load tag ownership and routes completions back to the owning channel.
module mem_arbiter
   import sys_defs::*;
#(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned RR_MODE = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_CH-1:0][`XLEN-1:0]         ch2arb_addr,
   input  logic [NUM_CH-1:0][`DATA_LENGTH-1:0]  ch2arb_data,
   input  logic [NUM_CH-1:0][1:0]               ch2arb_command,
   output logic [NUM_CH-1:0][TAG_W-1:0]         arb2ch_response,
   output logic [NUM_CH-1:0][TAG_W-1:0]         arb2ch_tag,
   output logic [NUM_CH-1:0][`DATA_LENGTH-1:0]  arb2ch_data,
   output logic [`XLEN-1:0]                     arb2mem_addr,
   output logic [`DATA_LENGTH-1:0]              arb2mem_data,
   output logic [1:0]                           arb2mem_command,
   input  logic [TAG_W-1:0]                     mem2arb_response,
   input  logic [TAG_W-1:0]                     mem2arb_tag,
   input  logic [`DATA_LENGTH-1:0]              mem2arb_data,
   output logic                                 tag_error
);

   localparam int unsigned PTR_W = $clog2(NUM_CH);
   localparam int unsigned NTAGS = (2 ** TAG_W) - 1;
   localparam int unsigned CNT_W = 4;

   logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [NTAGS:1]                own_vld_q, own_vld_d;
   logic [NTAGS:1][PTR_W-1:0]     own_id_q, own_id_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic                          tag_error_q, tag_error_d;

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] grant;
   logic [PTR_W-1:0]  gidx;
   logic [PTR_W-1:0]  cpl_owner;
   logic              any_grant, accept, load_acc, cpl_valid, cpl_hit, cpl_miss;

   // Reset gates eligibility, so every downstream output idles while rst is high.
   always_comb begin
      elig = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         elig[c] = !rst && (ch2arb_command[c] != BUS_NONE) &&
                   ((ch2arb_command[c] != BUS_LOAD) || (cnt_q[c] < CNT_W'(MAX_OUT)));
      end
   end

   rr_arbiter #(
      .NUM_CH  (NUM_CH),
      .RR_MODE (RR_MODE)
   ) u_rr_arbiter (
      .req   (elig),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   always_comb begin
      gidx = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (grant[c]) gidx = PTR_W'(c);
      end
   end

   assign any_grant = |grant;
   assign accept    = any_grant && (mem2arb_response != '0);
   assign load_acc  = accept && (ch2arb_command[gidx] == BUS_LOAD);
   assign cpl_valid = !rst && (mem2arb_tag != '0);
   assign cpl_hit   = cpl_valid && own_vld_q[mem2arb_tag];
   assign cpl_miss  = cpl_valid && !own_vld_q[mem2arb_tag];
   assign cpl_owner = own_id_q[mem2arb_tag];
   assign tag_error = tag_error_q;

   always_comb begin
      arb2mem_addr    = '0;
      arb2mem_data    = '0;
      arb2mem_command = BUS_NONE;
      arb2ch_response = '0;
      arb2ch_tag      = '0;
      arb2ch_data     = '0;
      if (any_grant) begin
         arb2mem_addr          = ch2arb_addr[gidx];
         arb2mem_data          = ch2arb_data[gidx];
         arb2mem_command       = ch2arb_command[gidx];
         arb2ch_response[gidx] = mem2arb_response;
      end
      if (cpl_hit) begin
         arb2ch_tag[cpl_owner]  = mem2arb_tag;
         arb2ch_data[cpl_owner] = mem2arb_data;
      end
   end

   // Completion clears before accept sets, so a same-cycle re-accept of the tag wins.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      own_vld_d   = own_vld_q;
      own_id_d    = own_id_q;
      tag_error_d = tag_error_q | cpl_miss;
      if (accept) begin
         rr_ptr_d = (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
      end
      if (cpl_hit) begin
         own_vld_d[mem2arb_tag] = 1'b0;
      end
      if (load_acc) begin
         own_vld_d[mem2arb_response] = 1'b1;
         own_id_d[mem2arb_response]  = gidx;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         cnt_d[c] = cnt_q[c]
                  + CNT_W'(load_acc && (gidx == PTR_W'(c)))
                  - CNT_W'(cpl_hit && (cpl_owner == PTR_W'(c)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         own_vld_q   <= '0;
         own_id_q    <= '0;
         cnt_q       <= '0;
         tag_error_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         own_vld_q   <= own_vld_d;
         own_id_q    <= own_id_d;
         cnt_q       <= cnt_d;
         tag_error_q <= tag_error_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a tag/count reference model.
module tb_mem_arbiter;
   import sys_defs::*;

   localparam int N    = 2;
   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0][`XLEN-1:0]        addr;
   logic [N-1:0][`DATA_LENGTH-1:0] data;
   logic [N-1:0][1:0]              cmd;
   logic [3:0]                     mresp, mtag;
   logic [`DATA_LENGTH-1:0]        mdata;

   logic [N-1:0][3:0]              rr_resp, rr_tag, fp_resp, fp_tag;
   logic [N-1:0][`DATA_LENGTH-1:0] rr_cdata, fp_cdata;
   logic [`XLEN-1:0]               rr_maddr, fp_maddr;
   logic [`DATA_LENGTH-1:0]        rr_mdata, fp_mdata;
   logic [1:0]                     rr_mcmd, fp_mcmd;
   logic                           rr_terr, fp_terr;

   mem_arbiter #(.NUM_CH(N), .TAG_W(4), .MAX_OUT(MAXO), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst),
      .ch2arb_addr(addr), .ch2arb_data(data), .ch2arb_command(cmd),
      .arb2ch_response(rr_resp), .arb2ch_tag(rr_tag), .arb2ch_data(rr_cdata),
      .arb2mem_addr(rr_maddr), .arb2mem_data(rr_mdata), .arb2mem_command(rr_mcmd),
      .mem2arb_response(mresp), .mem2arb_tag(mtag), .mem2arb_data(mdata),
      .tag_error(rr_terr)
   );

   mem_arbiter #(.NUM_CH(N), .TAG_W(4), .MAX_OUT(MAXO), .RR_MODE(0)) u_fp (
      .clk(clk), .rst(rst),
      .ch2arb_addr(addr), .ch2arb_data(data), .ch2arb_command(cmd),
      .arb2ch_response(fp_resp), .arb2ch_tag(fp_tag), .arb2ch_data(fp_cdata),
      .arb2mem_addr(fp_maddr), .arb2mem_data(fp_mdata), .arb2mem_command(fp_mcmd),
      .mem2arb_response(mresp), .mem2arb_tag(mtag), .mem2arb_data(mdata),
      .tag_error(fp_terr)
   );

   // Reference model of the round-robin instance: pointer, per-channel
   // outstanding loads, tag owner map (-1 = free) and the sticky error.
   int m_ptr;
   int m_cnt [N];
   int m_own [16];
   bit m_terr;
   int errors = 0;
   int checks = 0;

   function automatic int model_grant(input int start);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (start + k) % N;
         if (cmd[c] == BUS_STORE) return c;
         if (cmd[c] == BUS_LOAD && m_cnt[c] < MAXO) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      int g;
      g = model_grant(m_ptr);
      if (rst) begin
         m_ptr = 0;
         m_terr = 1'b0;
         for (int c = 0; c < N; c++) m_cnt[c] = 0;
         for (int t = 0; t < 16; t++) m_own[t] = -1;
      end else begin
         if (mtag != 0) begin
            if (m_own[mtag] >= 0) begin
               m_cnt[m_own[mtag]]--;
               m_own[mtag] = -1;
            end else begin
               m_terr = 1'b1;
            end
         end
         if (g >= 0 && mresp != 0) begin
            m_ptr = (g + 1) % N;
            if (cmd[g] == BUS_LOAD) begin
               m_own[mresp] = g;
               m_cnt[g]++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cmd = '0; mresp = '0; mtag = '0; mdata = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd[0] = BUS_LOAD; cmd[1] = BUS_STORE;
      mresp = 4'd3; mtag = 4'd2; mdata = 64'h1234;
      #1;
      checks++; if (rr_mcmd !== BUS_NONE) begin errors++; $display("FAIL reset_cmd: got %0d want %0d", rr_mcmd, BUS_NONE); end
      checks++; if (rr_resp !== '0) begin errors++; $display("FAIL reset_resp: got %h want 0", rr_resp); end
      checks++; if (rr_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", rr_tag); end
      tick();
      tick();
      checks++; if (rr_terr !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", rr_terr); end
      rst = 1'b0;
      idle();
      #1;
      checks++; if (rr_mcmd !== BUS_NONE) begin errors++; $display("FAIL idle_cmd: got %0d want %0d", rr_mcmd, BUS_NONE); end
   endtask

   task automatic test_rr_alternate();
      int exp_g [4] = '{0, 1, 0, 1};
      cmd[0] = BUS_LOAD; cmd[1] = BUS_LOAD;
      for (int i = 0; i < 4; i++) begin
         addr[0] = $urandom; addr[1] = addr[0] ^ 32'h1;
         data[0] = {$urandom, $urandom}; data[1] = {$urandom, $urandom};
         mresp = 4'(i + 1);
         #1;
         checks++; if (rr_maddr !== addr[exp_g[i]]) begin errors++; $display("FAIL alt_addr[%0d]: got %h want %h", i, rr_maddr, addr[exp_g[i]]); end
         checks++; if (rr_mdata !== data[exp_g[i]]) begin errors++; $display("FAIL alt_data[%0d]: got %h want %h", i, rr_mdata, data[exp_g[i]]); end
         checks++; if (rr_resp[exp_g[i]] !== mresp || rr_resp[1 - exp_g[i]] !== 4'd0) begin
            errors++; $display("FAIL alt_resp[%0d]: got %h want tag %0d on ch%0d", i, rr_resp, mresp, exp_g[i]);
         end
         tick();
      end
   endtask

   task automatic test_completion();
      int o;
      idle();
      for (int t = 1; t <= 4; t++) begin
         mtag = 4'(t); mdata = {$urandom, $urandom};
         o = (t - 1) % 2;
         #1;
         checks++; if (rr_tag[o] !== mtag || rr_tag[1 - o] !== 4'd0) begin errors++; $display("FAIL cpl_tag[%0d]: got %h want %0d on ch%0d", t, rr_tag, t, o); end
         checks++; if (rr_cdata[o] !== mdata) begin errors++; $display("FAIL cpl_data[%0d]: got %h want %h", t, rr_cdata[o], mdata); end
         tick();
      end
      idle();
      cmd[1] = BUS_LOAD; mresp = 4'd5;
      #1;
      checks++; if (rr_resp[1] !== 4'd5 || rr_resp[0] !== 4'd0) begin errors++; $display("FAIL ld5_resp: got %h want 5 on ch1", rr_resp); end
      tick();
      idle();
      mtag = 4'd5; mdata = 64'hDEAD_BEEF;
      #1;
      checks++; if (rr_tag[1] !== 4'd5 || rr_tag[0] !== 4'd0) begin errors++; $display("FAIL cpl5_tag: got %h want 5 on ch1 only", rr_tag); end
      checks++; if (rr_cdata[1] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL cpl5_data: got %h want deadbeef", rr_cdata[1]); end
      tick();
      idle();
      #1;
      checks++; if (rr_terr !== 1'b0) begin errors++; $display("FAIL cpl_terr: got %b want 0", rr_terr); end
   endtask

   task automatic test_max_out();
      do_reset();
      cmd[0] = BUS_LOAD;
      for (int t = 1; t <= 4; t++) begin
         mresp = 4'(t);
         tick();
      end
      mresp = 4'd5;
      #1;
      checks++; if (rr_mcmd !== BUS_NONE || rr_resp !== '0) begin errors++; $display("FAIL full_load: got cmd %0d resp %h want none", rr_mcmd, rr_resp); end
      tick();
      cmd[0] = BUS_STORE;
      #1;
      checks++; if (rr_mcmd !== BUS_STORE || rr_resp[0] !== 4'd5) begin errors++; $display("FAIL full_store: got cmd %0d resp %h want store tag 5", rr_mcmd, rr_resp); end
      tick();
      cmd[0] = BUS_LOAD; cmd[1] = BUS_LOAD;
      addr[0] = 32'hA000; addr[1] = 32'hB000; mresp = 4'd6;
      #1;
      checks++; if (rr_maddr !== 32'hB000 || rr_resp[1] !== 4'd6) begin errors++; $display("FAIL full_ch1: got addr %h resp %h want b000 tag 6", rr_maddr, rr_resp); end
      tick();
      idle();
      mtag = 4'd1;
      tick();
      // ch0 now at 3: accept tag 2 while tag 2 completes; count must stay 3
      idle();
      cmd[0] = BUS_LOAD; mresp = 4'd2; mtag = 4'd2; mdata = 64'h55;
      #1;
      checks++; if (rr_resp[0] !== 4'd2 || rr_tag[0] !== 4'd2) begin errors++; $display("FAIL simul: got resp %h tag %h want 2/2", rr_resp, rr_tag); end
      tick();
      idle();
      cmd[0] = BUS_LOAD; mresp = 4'd7;
      #1;
      checks++; if (rr_resp[0] !== 4'd7) begin errors++; $display("FAIL refill: got %h want 7", rr_resp[0]); end
      tick();
      mresp = 4'd8;
      #1;
      checks++; if (rr_mcmd !== BUS_NONE) begin errors++; $display("FAIL refull: got cmd %0d want none", rr_mcmd); end
      tick();
      idle();
      mtag = 4'd2; mdata = 64'h77;
      #1;
      checks++; if (rr_tag[0] !== 4'd2 || rr_cdata[0] !== 64'h77) begin errors++; $display("FAIL reaccept: got tag %h data %h want 2/77", rr_tag, rr_cdata[0]); end
      tick();
      idle();
      #1;
      checks++; if (rr_terr !== 1'b0) begin errors++; $display("FAIL maxout_terr: got %b want 0", rr_terr); end
   endtask

   task automatic test_hold();
      logic [`XLEN-1:0] first;
      do_reset();
      cmd[0] = BUS_LOAD; cmd[1] = BUS_LOAD;
      addr[0] = 32'h100; addr[1] = 32'h200;
      #1;
      first = rr_maddr;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (rr_resp !== '0) begin errors++; $display("FAIL hold_resp[%0d]: got %h want 0", i, rr_resp); end
         checks++; if (rr_maddr !== first || rr_maddr !== 32'h100) begin errors++; $display("FAIL hold_addr[%0d]: got %h want 100", i, rr_maddr); end
         tick();
      end
      mresp = 4'd9;
      #1;
      checks++; if (rr_resp[0] !== 4'd9) begin errors++; $display("FAIL hold_ptr: got %h want 9 on ch0", rr_resp); end
      tick();
      idle();
      mtag = 4'd1;
      #1;
      checks++; if (rr_tag !== '0) begin errors++; $display("FAIL hold_noown: got %h want 0", rr_tag); end
      tick();
      idle();
      #1;
      checks++; if (rr_terr !== 1'b1) begin errors++; $display("FAIL hold_terr: got %b want 1", rr_terr); end
   endtask

   task automatic test_midflight_reset();
      do_reset();
      cmd[0] = BUS_LOAD; mresp = 4'd7;
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mtag = 4'd7; mdata = 64'hF00D;
      #1;
      checks++; if (rr_tag !== '0) begin errors++; $display("FAIL mid_tag: got %h want 0", rr_tag); end
      tick();
      idle();
      #1;
      checks++; if (rr_terr !== 1'b1) begin errors++; $display("FAIL mid_terr: got %b want 1", rr_terr); end
   endtask

   task automatic test_fixed_prio();
      int g;
      do_reset();
      cmd[0] = BUS_STORE; cmd[1] = BUS_STORE;
      for (int i = 0; i < 6; i++) begin
         if (i >= 4) cmd[0] = BUS_LOAD;
         addr[0] = $urandom; addr[1] = addr[0] ^ 32'hFF;
         mresp = (i >= 4) ? 4'd0 : 4'($urandom_range(1, 15));
         #1;
         g = model_grant(m_ptr);
         checks++; if (fp_maddr !== addr[0] || fp_resp[0] !== mresp) begin errors++; $display("FAIL fp[%0d]: got addr %h resp %h want ch0", i, fp_maddr, fp_resp); end
         checks++; if (rr_maddr !== addr[g]) begin errors++; $display("FAIL fp_rr[%0d]: got %h want %h", i, rr_maddr, addr[g]); end
         tick();
      end
   endtask

   task automatic test_random();
      int g, o, cand;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int c = 0; c < N; c++) begin
            cmd[c]  = 2'($urandom_range(0, 2));
            addr[c] = $urandom;
            data[c] = {$urandom, $urandom};
         end
         mtag = '0;
         if ($urandom_range(0, 1) == 1) begin
            mtag = 4'($urandom_range(1, 15));
            for (int t = 1; t < 16; t++) if (m_own[t] >= 0 && $urandom_range(0, 2) == 0) mtag = 4'(t);
         end
         mdata = {$urandom, $urandom};
         mresp = '0;
         if ($urandom_range(0, 9) < 7) begin
            cand = $urandom_range(1, 15);
            if (m_own[cand] < 0 || (cand == mtag)) mresp = 4'(cand);
         end
         #1;
         g = rst ? -1 : model_grant(m_ptr);
         o = (!rst && mtag != 0) ? m_own[mtag] : -1;
         if (g < 0) begin
            checks++; if (rr_mcmd !== BUS_NONE) begin errors++; $display("FAIL rnd_cmd@%0d: got %0d want none", cyc, rr_mcmd); end
         end else begin
            checks++; if (rr_mcmd !== cmd[g] || rr_maddr !== addr[g] || rr_mdata !== data[g]) begin
               errors++; $display("FAIL rnd_fwd@%0d: got cmd %0d addr %h want ch%0d cmd %0d addr %h", cyc, rr_mcmd, rr_maddr, g, cmd[g], addr[g]);
            end
         end
         for (int c = 0; c < N; c++) begin
            checks++; if (rr_resp[c] !== ((g == c) ? mresp : 4'd0)) begin errors++; $display("FAIL rnd_resp@%0d ch%0d: got %h want %h", cyc, c, rr_resp[c], (g == c) ? mresp : 4'd0); end
            checks++; if (rr_tag[c] !== ((o == c) ? mtag : 4'd0)) begin errors++; $display("FAIL rnd_tag@%0d ch%0d: got %h want %h", cyc, c, rr_tag[c], (o == c) ? mtag : 4'd0); end
            if (o == c) begin
               checks++; if (rr_cdata[c] !== mdata) begin errors++; $display("FAIL rnd_cdata@%0d ch%0d: got %h want %h", cyc, c, rr_cdata[c], mdata); end
            end
         end
         checks++; if (rr_terr !== m_terr) begin errors++; $display("FAIL rnd_terr@%0d: got %b want %b", cyc, rr_terr, m_terr); end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      addr = '0; data = '0;
      idle();
      rst = 1'b1;
      m_ptr = 0; m_terr = 1'b0;
      for (int c = 0; c < N; c++) m_cnt[c] = 0;
      for (int t = 0; t < 16; t++) m_own[t] = -1;
      test_reset();
      test_rr_alternate();
      test_completion();
      test_max_out();
      test_hold();
      test_midflight_reset();
      test_fixed_prio();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting channels (2..8).
REQ-002 SHALL have parameter TAG_W, default 4, memory tag width; tag 0 means "none".
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum outstanding loads per channel (1..15).
REQ-004 SHALL have parameter RR_MODE, default 1; 1 selects round-robin, 0 selects fixed priority (lowest index wins).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ch2arb_addr  input  [NUM_CH][`XLEN]  per-channel request address.
REQ-008 SHALL have port ch2arb_data  input  [NUM_CH][`DATA_LENGTH]  per-channel store data.
REQ-009 SHALL have port ch2arb_command  input  [NUM_CH][2]  per-channel BUS_NONE/BUS_LOAD/BUS_STORE.
REQ-010 SHALL have port arb2ch_response  output  [NUM_CH][TAG_W]  acceptance tag to the granted channel, else 0.
REQ-011 SHALL have port arb2ch_tag  output  [NUM_CH][TAG_W]  completed load tag, routed to the owning channel, else 0.
REQ-012 SHALL have port arb2ch_data  output  [NUM_CH][`DATA_LENGTH]  load data, valid only when arb2ch_tag is nonzero.
REQ-013 SHALL have ports arb2mem_addr, arb2mem_data, arb2mem_command  output  `XLEN, `DATA_LENGTH, 2  forwarded winning request.
REQ-014 SHALL have ports mem2arb_response, mem2arb_tag, mem2arb_data  input  TAG_W, TAG_W, `DATA_LENGTH  memory accept tag, completion tag, completion data.
REQ-015 SHALL have port tag_error  output  1  sticky flag for a completion on an unowned tag.

Function
REQ-016 A channel SHALL be eligible when its command is not BUS_NONE and, for BUS_LOAD, its outstanding count is below MAX_OUT.
REQ-017 Exactly one eligible channel SHALL be granted per cycle, combinationally; with none eligible, arb2mem_command SHALL be BUS_NONE.
REQ-018 In RR_MODE=1, the search SHALL start at rr_ptr and wrap from NUM_CH-1 to 0.
REQ-019 rr_ptr SHALL advance to (grant+1) mod NUM_CH only when mem2arb_response is nonzero; otherwise it SHALL hold.
REQ-020 arb2mem_* SHALL equal the granted channel's inputs in the same cycle (zero-cycle forward).
REQ-021 mem2arb_response SHALL be copied to arb2ch_response of the granted channel only; all others SHALL read 0 and hold their request to retry.
REQ-022 On accepted BUS_LOAD, owner[tag] SHALL be set valid with the grant index, and that channel's count incremented at the next edge.
REQ-023 Accepted BUS_STORE SHALL NOT create an owner entry or change any count.
REQ-024 When mem2arb_tag is nonzero and owner[tag] is valid, arb2ch_tag/arb2ch_data of the owner SHALL show the tag and data in the same cycle; owner valid SHALL clear and the count decrement at the next edge.
REQ-025 When mem2arb_tag is nonzero and owner[tag] is invalid, no channel SHALL see it, and tag_error SHALL set at the next edge.
REQ-026 A simultaneous load accept and completion on one channel SHALL leave its count unchanged.
REQ-027 A simultaneous completion and re-accept of the same tag SHALL leave the entry valid with the new owner.
REQ-028 A count at MAX_OUT SHALL mask only that channel's loads; its stores SHALL remain eligible.

Reset
REQ-029 With rst high at an edge, rr_ptr SHALL be 0, all owner entries invalid, all counts 0, and tag_error 0.
REQ-030 While rst is high, arb2mem_command SHALL be BUS_NONE and all arb2ch_response and arb2ch_tag SHALL be 0.
REQ-031 Reset mid-operation SHALL drop all in-flight ownership; later completions SHALL set tag_error.

Structure
REQ-032 The BUS_COMMAND encoding, `XLEN and `DATA_LENGTH SHALL come from the shared sys_defs package; no local redefinition is permitted.
REQ-033 Grant selection SHALL be a sub-module rr_arbiter (NUM_CH, RR_MODE; inputs req and ptr; output one-hot grant).
REQ-034 The owner table SHALL have 2^TAG_W-1 entries indexed by tag, each holding a valid bit and a $clog2(NUM_CH)-bit owner.

Verification
REQ-035 Ch0 and ch1 both LOAD every cycle, memory accepts tags 1,2,3,4 -> grants alternate 0,1,0,1.
REQ-036 RR_MODE=0 with both requesting -> ch0 is always granted while it is eligible.
REQ-037 Ch1 LOAD accepted with tag 5, then mem2arb_tag=5 with data 64'hDEAD_BEEF -> only arb2ch_tag[1]=5 and arb2ch_data[1]=DEAD_BEEF; count returns to 0.
REQ-038 Ch0 issues 4 unanswered loads (MAX_OUT=4) -> ch0 LOAD is no longer granted, ch0 STORE is still granted, and ch1 is served.
REQ-039 mem2arb_response=0 for 3 cycles -> requests held, rr_ptr unchanged, no owner entry created.
REQ-040 Reset with tag 7 outstanding, then mem2arb_tag=7 -> no channel output, and tag_error=1 one cycle later.
